// File: rtl/cram_arbiter.sv
// Arbitrates a byte-wide loader (writes) and sound-sample reader onto a 16-bit CRAM port.
// Reads win ties until MAX_RD_STREAK consecutive read grants have starved a waiting write.
module cram_arbiter #(
   parameter int ADDR_WIDTH    = 23,
   parameter int MAX_RD_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [7:0]            wr_data,
   output logic                  wr_ack,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_ack,
   output logic [7:0]            rd_data,
   output logic [ADDR_WIDTH-2:0] mem_addr,
   output logic [15:0]           mem_wr_data,
   output logic [1:0]            mem_be,
   output logic                  mem_wr,
   output logic                  mem_rd,
   input  logic                  mem_busy,
   input  logic                  mem_rd_valid,
   input  logic [15:0]           mem_rd_data,
   output logic                  active
);

   localparam int SW = $clog2(MAX_RD_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_STREAK);

   typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT} state_t;

   state_t                state_q, state_d;
   logic [SW-1:0]         streak_q, streak_d;
   logic [ADDR_WIDTH-2:0] addr_q;
   logic [1:0]            be_q;
   logic [7:0]            byte_q;
   logic                  rd_ack_q;
   logic [7:0]            rd_data_q;
   logic                  grant_rd, grant_wr, rd_done;

   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      grant_rd = 1'b0;
      grant_wr = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_req && (!wr_req || streak_q != STREAK_MAX)) begin
               grant_rd = 1'b1;
               state_d  = RD_ISSUE;
               // Only reads that actually hold off a pending write count toward the streak.
               if (wr_req)
                  streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
               else
                  streak_d = '0;
            end else if (wr_req) begin
               grant_wr = 1'b1;
               state_d  = WR_ISSUE;
               streak_d = '0;
            end
         end
         WR_ISSUE: if (!mem_busy) state_d = IDLE;
         RD_ISSUE: if (!mem_busy) state_d = RD_WAIT;
         RD_WAIT:  if (mem_rd_valid) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   assign rd_done = (state_q == RD_WAIT) && mem_rd_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         streak_q  <= '0;
         addr_q    <= '0;
         be_q      <= 2'b00;
         byte_q    <= 8'h00;
         rd_ack_q  <= 1'b0;
         rd_data_q <= 8'h00;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         rd_ack_q <= rd_done;
         if (grant_rd) begin
            addr_q <= rd_addr[ADDR_WIDTH-1:1];
            be_q   <= {rd_addr[0], ~rd_addr[0]};
         end else if (grant_wr) begin
            addr_q <= wr_addr[ADDR_WIDTH-1:1];
            be_q   <= {wr_addr[0], ~wr_addr[0]};
            byte_q <= wr_data;
         end
         // be_q[1] doubles as the latched odd-address flag for lane selection.
         if (rd_done)
            rd_data_q <= be_q[1] ? mem_rd_data[15:8] : mem_rd_data[7:0];
      end
   end

   assign mem_wr      = (state_q == WR_ISSUE);
   assign mem_rd      = (state_q == RD_ISSUE);
   assign wr_ack      = mem_wr && !mem_busy;
   assign rd_ack      = rd_ack_q;
   assign rd_data     = rd_data_q;
   assign mem_addr    = addr_q;
   assign mem_be      = be_q;
   assign mem_wr_data = {byte_q, byte_q};
   assign active      = (state_q != IDLE);

endmodule

// File: tb/tb_cram_arbiter.sv
// Directed bench for cram_arbiter: expected memory commands and read bytes are queued
// by the stimulus and popped by an independent negedge monitor.
module tb_cram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        wr_req, rd_req, wr_ack, rd_ack;
   logic [22:0] wr_addr, rd_addr;
   logic [7:0]  wr_data, rd_data;
   logic [21:0] mem_addr;
   logic [15:0] mem_wr_data, mem_rd_data;
   logic [1:0]  mem_be;
   logic        mem_wr, mem_rd, mem_busy, mem_rd_valid, active;

   typedef struct {
      logic        wr;
      logic [21:0] addr;
      logic [1:0]  be;
      logic [15:0] wdata;
   } cmd_t;

   cmd_t       exp_cmd[$];
   logic [7:0] exp_rd[$];
   cmd_t       mon_c;
   logic [7:0] mon_b;
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   cram_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_be(mem_be),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_busy(mem_busy),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .active(active)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted command and every rd_ack must match the head of its queue.
   always @(negedge clk) begin
      if (reset_n) begin
         if (mem_wr || mem_rd)
            check("cmd_exclusive", 32'(mem_wr && mem_rd), 32'h0);
         if ((mem_wr || mem_rd) && !mem_busy) begin
            if (exp_cmd.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_cmd: actual wr=%0b addr=%0h required none", mem_wr, mem_addr);
            end else begin
               mon_c = exp_cmd.pop_front();
               check("cmd_kind", 32'(mem_wr), 32'(mon_c.wr));
               check("mem_addr", 32'(mem_addr), 32'(mon_c.addr));
               check("mem_be", 32'(mem_be), 32'(mon_c.be));
               if (mon_c.wr) check("mem_wr_data", 32'(mem_wr_data), 32'(mon_c.wdata));
            end
         end
         if (wr_ack || (mem_wr && !mem_busy))
            check("wr_ack_on_accept", 32'(wr_ack), 32'(mem_wr && !mem_busy));
         if (rd_ack) begin
            if (exp_rd.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rd_ack: actual rd_data=%0h required no ack", rd_data);
            end else begin
               mon_b = exp_rd.pop_front();
               check("rd_data", 32'(rd_data), 32'(mon_b));
            end
         end
      end
   end

   task automatic do_write(input logic [22:0] a, input logic [7:0] d);
      bit ok;
      exp_cmd.push_back('{1'b1, a[22:1], {a[0], ~a[0]}, {d, d}});
      wr_req = 1'b1; wr_addr = a; wr_data = d;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wr_ack) begin ok = 1'b1; break; end
      end
      check("wr_ack_seen", 32'(ok), 32'h1);
      tick();
      wr_req = 1'b0;
   endtask

   initial begin
      int   cnt;
      bit   ok;
      logic [9:0] obs;

      reset_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0;
      mem_busy = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
      repeat (2) @(negedge clk);
      check("rst_cmds", 32'({mem_wr, mem_rd, wr_ack, rd_ack, active}), 32'h0);
      check("rst_rd_data", 32'(rd_data), 32'h0);
      check("rst_mem_bus", 32'(mem_addr) | 32'(mem_be) | 32'(mem_wr_data), 32'h0);
      tick();
      reset_n = 1'b1;
      tick();

      // Write to odd address: command and ack one cycle after the request.
      exp_cmd.push_back('{1'b1, 22'h000001, 2'b10, 16'hA5A5});
      wr_req = 1'b1; wr_addr = 23'h000003; wr_data = 8'hA5;
      @(negedge clk);
      check("wr_not_early", 32'(mem_wr), 32'h0);
      @(negedge clk);
      check("wr_ack_latency", 32'(wr_ack), 32'h1);
      tick();
      wr_req = 1'b0;
      @(negedge clk);
      check("idle_after_wr", 32'(active), 32'h0);
      tick();
      do_write(23'h7FFFFE, 8'h3C);

      // Read stalled by mem_busy for three cycles.
      exp_cmd.push_back('{1'b0, 22'h000008, 2'b01, 16'h0000});
      exp_rd.push_back(8'h34);
      rd_req = 1'b1; rd_addr = 23'h000010; mem_busy = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_rd) begin
            cnt++;
            if (!mem_busy) break;
            if (cnt == 3) begin tick(); mem_busy = 1'b0; end
         end
      end
      mem_busy = 1'b0;
      check("mem_rd_hold_cycles", 32'(cnt), 32'd4);
      tick(); tick(); tick();
      mem_rd_valid = 1'b1; mem_rd_data = 16'h1234;
      tick();
      mem_rd_valid = 1'b0; rd_req = 1'b0;
      @(negedge clk);
      check("rd_ack_latency", 32'(rd_ack), 32'h1);
      @(negedge clk);
      check("rd_ack_pulse", 32'(rd_ack), 32'h0);
      check("rd_data_hold", 32'(rd_data), 32'h34);
      tick();

      // Stray mem_rd_valid while idle.
      mem_rd_valid = 1'b1; mem_rd_data = 16'hFFFF;
      tick();
      mem_rd_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rd_ack) cnt++;
      end
      check("idle_valid_no_ack", 32'(cnt), 32'h0);
      check("idle_valid_rd_data", 32'(rd_data), 32'h34);
      tick();

      // Odd-address read, request and address dropped right after the grant.
      exp_cmd.push_back('{1'b0, 22'h000010, 2'b10, 16'h0000});
      exp_rd.push_back(8'hBE);
      rd_req = 1'b1; rd_addr = 23'h000021;
      tick();
      rd_req = 1'b0; rd_addr = 23'h000000;
      tick();
      tick();
      mem_rd_valid = 1'b1; mem_rd_data = 16'hBEEF;
      tick();
      mem_rd_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rd_ack) cnt++;
      end
      check("dropped_req_ack_once", 32'(cnt), 32'h1);
      check("dropped_req_rd_data", 32'(rd_data), 32'hBE);
      tick();

      // Both requesters continuously asserting: expect R,R,R,R,W,R,R,R,R,W.
      for (int g = 0; g < 10; g++) begin
         if (g == 4 || g == 9) exp_cmd.push_back('{1'b1, 22'h000100, 2'b10, 16'h5A5A});
         else begin
            exp_cmd.push_back('{1'b0, 22'h000080, 2'b01, 16'h0000});
            exp_rd.push_back(8'hC3);
         end
      end
      rd_req = 1'b1; rd_addr = 23'h000100;
      wr_req = 1'b1; wr_addr = 23'h000201; wr_data = 8'h5A;
      obs = '0;
      for (int g = 0; g < 10; g++) begin
         ok = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_wr || mem_rd) begin ok = 1'b1; break; end
         end
         if (!ok) begin
            check("grant_timeout", 32'(g), 32'd10);
            break;
         end
         obs[g] = mem_wr;
         tick();
         if (!obs[g]) begin
            mem_rd_valid = 1'b1; mem_rd_data = 16'h77C3;
            tick();
            mem_rd_valid = 1'b0;
         end
      end
      rd_req = 1'b0; wr_req = 1'b0;
      check("grant_order", 32'(obs), 32'h210);
      repeat (3) tick();

      // Reset while waiting for read data.
      exp_cmd.push_back('{1'b0, 22'h000020, 2'b01, 16'h0000});
      rd_req = 1'b1; rd_addr = 23'h000040;
      tick();
      rd_req = 1'b0;
      tick();
      #2 reset_n = 1'b0;
      #1;
      check("rst_async_mem_rd", 32'(mem_rd), 32'h0);
      check("rst_async_active", 32'(active), 32'h0);
      tick();
      reset_n = 1'b1;
      tick();
      mem_rd_valid = 1'b1; mem_rd_data = 16'hABCD;
      tick();
      mem_rd_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rd_ack) cnt++;
      end
      check("rst_abort_no_ack", 32'(cnt), 32'h0);
      check("rst_abort_rd_data", 32'(rd_data), 32'h0);
      check("rst_abort_active", 32'(active), 32'h0);

      check("cmd_queue_drained", 32'(exp_cmd.size()), 32'h0);
      check("rd_queue_drained", 32'(exp_rd.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cram_arbiter.md
CRAM_ARBITER -- requirements
Module: cram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 23, byte-address width of both requesters.
REQ-002 Parameter MAX_RD_STREAK, default 4, consecutive read grants allowed while a write waits.
REQ-003 clk  input  1  single core clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_req  input  1  loader write request, held high until wr_ack.
REQ-006 wr_addr  input  ADDR_WIDTH  loader byte address.
REQ-007 wr_data  input  8  loader byte.
REQ-008 wr_ack  output  1  one-cycle pulse, write accepted by memory.
REQ-009 rd_req  input  1  sound-sample read request, held high until rd_ack.
REQ-010 rd_addr  input  ADDR_WIDTH  sample byte address.
REQ-011 rd_ack  output  1  one-cycle pulse, rd_data valid.
REQ-012 rd_data  output  8  returned byte.
REQ-013 mem_addr  output  ADDR_WIDTH-1  word address to CRAM controller.
REQ-014 mem_wr_data  output  16  write word.
REQ-015 mem_be  output  2  byte enables, bit0 = low byte.
REQ-016 mem_wr  output  1  write command, held until accepted.
REQ-017 mem_rd  output  1  read command, held until accepted.
REQ-018 mem_busy  input  1  controller cannot accept; command accepted on any cycle mem_wr|mem_rd high and mem_busy low.
REQ-019 mem_rd_valid  input  1  one-cycle pulse, mem_rd_data valid.
REQ-020 mem_rd_data  input  16  read word.
REQ-021 active  output  1  high whenever state is not IDLE.

Function
REQ-022 States IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT; no others.
REQ-023 IDLE: rd_req only -> RD_ISSUE; wr_req only -> WR_ISSUE; neither -> stay.
REQ-024 IDLE, both requests: read wins unless streak == MAX_RD_STREAK, then write wins.
REQ-025 Streak counter: +1 on a read grant while wr_req high; cleared on write grant or on read grant with wr_req low; saturates at MAX_RD_STREAK.
REQ-026 On grant, address/data/addr[0] latched; requester changes after grant have no effect on the transaction.
REQ-027 mem_addr = latched addr[ADDR_WIDTH-1:1]; mem_be = 2'b01 for addr[0]=0, 2'b10 for addr[0]=1; mem_wr_data = {byte, byte}.
REQ-028 mem_wr high throughout WR_ISSUE; on acceptance cycle wr_ack pulses, next state IDLE.
REQ-029 mem_rd high throughout RD_ISSUE; on acceptance cycle next state RD_WAIT, no ack yet.
REQ-030 RD_WAIT: on mem_rd_valid, rd_data registers low byte (addr[0]=0) or high byte (addr[0]=1); rd_ack pulses the following cycle with that data; then IDLE.
REQ-031 rd_data holds its value until the next read completes.
REQ-032 Latency, mem_busy low: write req at cycle N -> mem_wr and wr_ack at N+1 -> IDLE at N+2; read req at N -> mem_rd at N+1 -> rd_ack one cycle after mem_rd_valid.
REQ-033 mem_wr and mem_rd never high together; mem_addr/mem_be/mem_wr_data stable while command held.
REQ-034 mem_rd_valid outside RD_WAIT ignored.
REQ-035 Request dropped after grant: transaction completes, ack still pulses once.
REQ-036 No timeout; RD_WAIT holds indefinitely awaiting mem_rd_valid.

Reset
REQ-037 reset_n low asynchronously forces IDLE, streak 0, wr_ack/rd_ack/mem_wr/mem_rd/active 0, rd_data 8'h00, mem_addr/mem_be/mem_wr_data 0.
REQ-038 Reset mid-transaction aborts it with no ack; after release the first grant is taken from IDLE.

Verification
REQ-039 wr_req, wr_addr=23'h000003, wr_data=8'hA5, mem_busy low -> next cycle mem_addr=22'h000001, mem_be=2'b10, mem_wr_data=16'hA5A5, wr_ack pulse.
REQ-040 rd_req, rd_addr=23'h000010; mem_busy high 3 cycles -> mem_rd held 4 cycles; mem_rd_valid with 16'h1234 -> rd_ack next cycle, rd_data=8'h34.
REQ-041 rd_req and wr_req continuously high, MAX_RD_STREAK=4 -> grant order R,R,R,R,W,R,R,R,R,W.
REQ-042 mem_rd_valid pulsed while IDLE -> no rd_ack, rd_data unchanged.
REQ-043 reset_n low in RD_WAIT -> mem_rd 0 and active 0 immediately; later mem_rd_valid yields no rd_ack.
REQ-044 rd_req dropped one cycle after grant, odd address, mem_rd_data 16'hBEEF -> rd_ack pulses once, rd_data=8'hBE.
